led_pattern_engine: RTL and testbench
=====================================

// Module: led_pattern_engine
// PURPOSE
//   Parametrised multi-mode pattern register driving the board LED bar. Successor to the plain
//   serial-in shift register: adds rotate, ping-pong (bounce) and up/down count modes, direction
//   control, parallel load and an end-of-sweep pulse. Sits between strobe_gen/sync_and_debounce
//   outputs and the (active-low) LED pins. The top level inverts out_reg for the LEDs.
// PARAMETERS
//   W          12   register width, number of LEDs; legal range W >= 2
//   RESET_VAL  0    W-bit value loaded into out_reg on reset
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   step strobe, one clk wide, from strobe_gen
//   mode       in   2   0 SHIFT, 1 ROTATE, 2 BOUNCE, 3 COUNT; sampled only on step cycles
//   dir        in   1   0 = left/up (toward MSB), 1 = right/down (toward LSB); ignored in BOUNCE
//   in         in   1   serial data bit for SHIFT mode (debounced key)
//   load       in   1   synchronous parallel load request
//   load_data  in   W   value written by load
//   out_reg    out  W   pattern register (active-high)
//   wrap       out  1   registered one-cycle pulse on sweep end / overflow
//   bounce_dir out  1   current internal BOUNCE direction, 0 = moving toward MSB
// BEHAVIOUR
//   Reset (rst_n=0, async): out_reg=RESET_VAL, wrap=0, bounce_dir=0. Outputs hold until a step.
//   Priority each clk: load > en > hold. load=1: out_reg<=load_data, wrap<=0, bounce_dir<=0,
//     regardless of en. en=0 and load=0: all state holds, wrap<=0.
//   Step (en=1, load=0), one step per strobe, result visible cycle after en:
//   SHIFT : dir=0 out<={out[W-2:0],in}; dir=1 out<={in,out[W-1:1]}. wrap<=1 iff the bit
//     shifted out (out[W-1] for dir=0, out[0] for dir=1) is 1.
//   ROTATE: dir=0 out<={out[W-2:0],out[W-1]}; dir=1 out<={out[0],out[W-1:1]}.
//     wrap<=1 iff the bit crossing the end (out[W-1] resp. out[0]) is 1.
//   BOUNCE: register must be one-hot. If out is not exactly one-hot (zero or >1 bit set):
//     out<=1 (bit 0), bounce_dir<=0, wrap<=0. Otherwise move the bit one place in bounce_dir;
//     when the new position is bit W-1 (moving up) or bit 0 (moving down) bounce_dir toggles in
//     the same step and wrap<=1. Sequence for W=4 from 0001: 0010,0100,1000*,0100,0010,0001*,...
//     (* = wrap pulse, bounce_dir flips). Stepping never leaves a one-hot value.
//   COUNT : dir=0 out<=out+1, wrap<=1 when out was all ones (wraps to 0);
//     dir=1 out<=out-1, wrap<=1 when out was 0 (wraps to all ones). Arithmetic is modulo 2^W.
//   wrap is high exactly one clk after the step that caused it, low otherwise.
//   Mode change: no reset of contents; new mode applies from the next step on the current value
//     (BOUNCE normalises as above). bounce_dir only changes in BOUNCE steps, on load or reset.
//   en and load both high: load wins, no step performed, strobe is lost (not queued).
//   Reset asserted mid-sweep: immediate return to reset values; no step on the rst_n rising edge.
//   No combinational path from inputs to outputs; all outputs are flops.
// TESTING
//   1 Reset W=12 RESET_VAL=0: rst_n low mid-run -> out_reg=000, wrap=0, bounce_dir=0 same cycle.
//   2 SHIFT dir=0, in=1 for 12 steps from 0 -> FFF after 12th step, wrap=0 all along; one more
//     step with in=0 -> FFE, wrap=1 for exactly one clk.
//   3 ROTATE dir=1 load 001 -> step -> 800 with wrap=1; step -> 400 wrap=0; 12 steps -> 001.
//   4 BOUNCE W=4 from 0000 -> 0001, then 0010,0100,1000(wrap,bounce_dir=1),0100,0010,
//     0001(wrap,bounce_dir=0); load 0110 then step -> 0001.
//   5 COUNT: load FFF, dir=0 step -> 000 wrap=1; dir=1 step -> FFF wrap=1; step -> FFE wrap=0.
//   6 load=1 with en=1, load_data=A5A -> out_reg=A5A, no step, wrap=0; en=0 holds for 100 clks.

Source files
------------

// File: rtl/led_pattern_engine.sv
// Multi-mode LED bar pattern register: shift, rotate, bounce and up/down count,
// with parallel load and a registered end-of-sweep pulse.
module led_pattern_engine #(
  parameter int unsigned    W         = 12,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         dir,
  input  logic         in,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] out_reg,
  output logic         wrap,
  output logic         bounce_dir
);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  logic [W-1:0] nxt_out;
  logic         nxt_wrap;
  logic         nxt_bdir;
  logic         bnc_up;

  always_comb begin
    nxt_out  = out_reg;
    nxt_wrap = 1'b0;
    nxt_bdir = bounce_dir;
    bnc_up   = ~bounce_dir;
    if (load) begin
      nxt_out  = load_data;
      nxt_bdir = 1'b0;
    end else if (en) begin
      unique case (mode_t'(mode))
        MODE_SHIFT: begin
          if (!dir) begin
            nxt_out  = {out_reg[W-2:0], in};
            nxt_wrap = out_reg[W-1];
          end else begin
            nxt_out  = {in, out_reg[W-1:1]};
            nxt_wrap = out_reg[0];
          end
        end
        MODE_ROTATE: begin
          if (!dir) begin
            nxt_out  = {out_reg[W-2:0], out_reg[W-1]};
            nxt_wrap = out_reg[W-1];
          end else begin
            nxt_out  = {out_reg[0], out_reg[W-1:1]};
            nxt_wrap = out_reg[0];
          end
        end
        MODE_BOUNCE: begin
          if (!$onehot(out_reg)) begin
            nxt_out  = {{(W-1){1'b0}}, 1'b1};
            nxt_bdir = 1'b0;
          end else begin
            // A loaded bit already sitting at the end it is heading for reflects
            // first, so a step can never push the bit off the register.
            if (bnc_up && out_reg[W-1])
              bnc_up = 1'b0;
            else if (!bnc_up && out_reg[0])
              bnc_up = 1'b1;
            nxt_out = bnc_up ? (out_reg << 1) : (out_reg >> 1);
            if (bnc_up && nxt_out[W-1]) begin
              nxt_bdir = 1'b1;
              nxt_wrap = 1'b1;
            end else if (!bnc_up && nxt_out[0]) begin
              nxt_bdir = 1'b0;
              nxt_wrap = 1'b1;
            end else begin
              nxt_bdir = ~bnc_up;
            end
          end
        end
        MODE_COUNT: begin
          if (!dir) begin
            nxt_out  = out_reg + 1'b1;
            nxt_wrap = &out_reg;
          end else begin
            nxt_out  = out_reg - 1'b1;
            nxt_wrap = ~|out_reg;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg    <= RESET_VAL;
      wrap       <= 1'b0;
      bounce_dir <= 1'b0;
    end else begin
      out_reg    <= nxt_out;
      wrap       <= nxt_wrap;
      bounce_dir <= nxt_bdir;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: a 12-bit instance for shift/rotate/count/load
// and a 4-bit instance for the bounce sequence.
module tb_led_pattern_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        dir, in;
  logic        en12, load12, en4, load4;
  logic [11:0] ld12, out12;
  logic [3:0]  ld4, out4;
  logic        wrap12, bd12, wrap4, bd4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_pattern_engine #(.W(12), .RESET_VAL(12'h000)) dut12 (
    .clk(clk), .rst_n(rst_n), .en(en12), .mode(mode), .dir(dir), .in(in),
    .load(load12), .load_data(ld12), .out_reg(out12), .wrap(wrap12), .bounce_dir(bd12)
  );

  led_pattern_engine #(.W(4), .RESET_VAL(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode), .dir(dir), .in(in),
    .load(load4), .load_data(ld4), .out_reg(out4), .wrap(wrap4), .bounce_dir(bd4)
  );

  task automatic step12();
    en12 = 1'b1;
    @(posedge clk); #1;
    en12 = 1'b0;
  endtask

  task automatic step4();
    en4 = 1'b1;
    @(posedge clk); #1;
    en4 = 1'b0;
  endtask

  task automatic load_12(input logic [11:0] v);
    ld12 = v; load12 = 1'b1;
    @(posedge clk); #1;
    load12 = 1'b0;
  endtask

  task automatic load_4(input logic [3:0] v);
    ld4 = v; load4 = 1'b1;
    @(posedge clk); #1;
    load4 = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({out12, wrap12, bd12} !== {12'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_initial got out=%h wrap=%b bd=%b want 000/0/0", out12, wrap12, bd12);
    end
    mode = 2'd3; dir = 1'b0;
    step12(); step12(); step12();
    vectors++;
    if (out12 !== 12'h003) begin
      miscompares++;
      $display("FAIL reset_prerun got out=%h want 003", out12);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out12, wrap12, bd12, out4, wrap4, bd4} !== {12'h000, 2'b00, 4'h0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_async got out12=%h w=%b bd=%b out4=%h w=%b bd=%b want all zero",
               out12, wrap12, bd12, out4, wrap4, bd4);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_shift();
    mode = 2'd0; dir = 1'b0; in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step12();
      vectors++;
      if (wrap12 !== 1'b0) begin
        miscompares++;
        $display("FAIL shift_fill_wrap step %0d got wrap=%b want 0", i, wrap12);
      end
    end
    vectors++;
    if (out12 !== 12'hFFF) begin
      miscompares++;
      $display("FAIL shift_fill got out=%h want FFF", out12);
    end
    in = 1'b0;
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'hFFE, 1'b1}) begin
      miscompares++;
      $display("FAIL shift_out got out=%h wrap=%b want FFE/1", out12, wrap12);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out12, wrap12} !== {12'hFFE, 1'b0}) begin
      miscompares++;
      $display("FAIL shift_wrap_pulse got out=%h wrap=%b want FFE/0", out12, wrap12);
    end
  endtask

  task automatic test_rotate();
    load_12(12'h001);
    mode = 2'd1; dir = 1'b1;
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'h800, 1'b1}) begin
      miscompares++;
      $display("FAIL rotate_cross got out=%h wrap=%b want 800/1", out12, wrap12);
    end
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'h400, 1'b0}) begin
      miscompares++;
      $display("FAIL rotate_next got out=%h wrap=%b want 400/0", out12, wrap12);
    end
    for (int i = 0; i < 10; i++) step12();
    vectors++;
    if ({out12, wrap12} !== {12'h001, 1'b0}) begin
      miscompares++;
      $display("FAIL rotate_full got out=%h wrap=%b want 001/0", out12, wrap12);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] seq [7];
    seq[0] = {4'b0001, 1'b0, 1'b0};
    seq[1] = {4'b0010, 1'b0, 1'b0};
    seq[2] = {4'b0100, 1'b0, 1'b0};
    seq[3] = {4'b1000, 1'b1, 1'b1};
    seq[4] = {4'b0100, 1'b0, 1'b1};
    seq[5] = {4'b0010, 1'b0, 1'b1};
    seq[6] = {4'b0001, 1'b1, 1'b0};
    mode = 2'd2; dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step4();
      vectors++;
      if ({out4, wrap4, bd4} !== seq[i]) begin
        miscompares++;
        $display("FAIL bounce_seq step %0d got out=%b wrap=%b bd=%b want %b/%b/%b",
                 i, out4, wrap4, bd4, seq[i][5:2], seq[i][1], seq[i][0]);
      end
    end
    load_4(4'b0110);
    step4();
    vectors++;
    if ({out4, wrap4, bd4} !== {4'b0001, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL bounce_normalise got out=%b wrap=%b bd=%b want 0001/0/0", out4, wrap4, bd4);
    end
  endtask

  task automatic test_count();
    load_12(12'hFFF);
    mode = 2'd3; dir = 1'b0;
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'h000, 1'b1}) begin
      miscompares++;
      $display("FAIL count_up_wrap got out=%h wrap=%b want 000/1", out12, wrap12);
    end
    dir = 1'b1;
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'hFFF, 1'b1}) begin
      miscompares++;
      $display("FAIL count_down_wrap got out=%h wrap=%b want FFF/1", out12, wrap12);
    end
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'hFFE, 1'b0}) begin
      miscompares++;
      $display("FAIL count_down got out=%h wrap=%b want FFE/0", out12, wrap12);
    end
  endtask

  task automatic test_load_priority();
    mode = 2'd3; dir = 1'b0;
    ld12 = 12'hA5A; load12 = 1'b1; en12 = 1'b1;
    @(posedge clk); #1;
    load12 = 1'b0; en12 = 1'b0;
    vectors++;
    if ({out12, wrap12, bd12} !== {12'hA5A, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL load_priority got out=%h wrap=%b bd=%b want A5A/0/0", out12, wrap12, bd12);
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out12, wrap12} !== {12'hA5A, 1'b0}) begin
        miscompares++;
        $display("FAIL hold cycle %0d got out=%h wrap=%b want A5A/0", i, out12, wrap12);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Mode change on the live value, then consecutive strobes.
    mode = 2'd1; dir = 1'b0;
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'h4B5, 1'b1}) begin
      miscompares++;
      $display("FAIL rotate_left got out=%h wrap=%b want 4B5/1", out12, wrap12);
    end
    mode = 2'd0; dir = 1'b1; in = 1'b1;
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'hA5A, 1'b1}) begin
      miscompares++;
      $display("FAIL shift_right got out=%h wrap=%b want A5A/1", out12, wrap12);
    end
    in = 1'b0;
    step12();
    vectors++;
    if ({out12, wrap12} !== {12'h52D, 1'b0}) begin
      miscompares++;
      $display("FAIL shift_right_b2b got out=%h wrap=%b want 52D/0", out12, wrap12);
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; dir = 1'b0; in = 1'b0;
    en12 = 1'b0; load12 = 1'b0; ld12 = '0;
    en4 = 1'b0; load4 = 1'b0; ld4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_shift();
    test_rotate();
    test_bounce();
    test_count();
    test_load_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
